// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam int unsigned MAX_STARVE_DEF = 4;

  // All-zero byte strobe marks a load; also driven to memory on fetches.
  localparam int unsigned WSTRB_LOAD = 0;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side fetch/data ports plus the unified memory macro port.
interface mem_port_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  logic              i_req;
  logic [XLEN-1:0]   i_addr;
  logic              i_ready;
  logic              i_rvalid;
  logic [XLEN-1:0]   i_rdata;

  logic              d_req;
  logic [XLEN-1:0]   d_addr;
  logic [XLEN-1:0]   d_wdata;
  logic [XLEN/8-1:0] d_wstrb;
  logic              d_ready;
  logic              d_rvalid;
  logic [XLEN-1:0]   d_rdata;

  logic              mem_en;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_wstrb;
  logic [XLEN-1:0]   mem_rdata;

  // Arbiter view.
  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_wdata, d_wstrb, mem_rdata,
    output i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
           mem_en, mem_addr, mem_wdata, mem_wstrb
  );

  // Core + memory view.
  modport master (
    output i_req, i_addr, d_req, d_addr, d_wdata, d_wstrb, mem_rdata,
    input  i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
           mem_en, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive cycles the fetch port lost arbitration.
module arb_starve_ctr #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);
  localparam int unsigned W = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam logic [W-1:0] MAXV = W'(MAX);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAXV)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_max = (r_cnt == MAXV);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 1-cycle-latency memory between fetch and data ports; data wins
// by default, fetch is forced through after MAX_STARVE consecutive losses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MAX_STARVE = MAX_STARVE_DEF,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus,
  output logic [CNT_W-1:0]  conflict_cnt
);
  logic       w_grant_i;
  logic       w_grant_d;
  logic       w_both;
  logic       w_at_max;
  owner_t     r_resp_owner;
  logic [CNT_W-1:0] r_conflict_cnt;

  // Grants are qualified by reset so every output reads 0 while it is held.
  always_comb begin
    w_both    = bus.i_req & bus.d_req;
    w_grant_i = reset & bus.i_req & (~bus.d_req | w_at_max);
    w_grant_d = reset & bus.d_req & ~w_grant_i;
  end

  arb_starve_ctr #(.MAX(MAX_STARVE)) u_starve (
    .clk      (clk),
    .rst_n    (reset),
    .i_inc    (bus.i_req & w_grant_d),
    .i_clr    (w_grant_i | ~bus.i_req),
    .o_at_max (w_at_max)
  );

  always_comb begin
    bus.i_ready   = w_grant_i;
    bus.d_ready   = w_grant_d;
    bus.mem_en    = w_grant_i | w_grant_d;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = (XLEN/8)'(WSTRB_LOAD);
    if (w_grant_d) begin
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
      bus.mem_wstrb = bus.d_wstrb;
    end else if (w_grant_i) begin
      bus.mem_addr  = bus.i_addr;
    end
  end

  always_comb begin
    bus.i_rvalid = (r_resp_owner == OWN_I);
    bus.d_rvalid = (r_resp_owner == OWN_D);
    bus.i_rdata  = bus.i_rvalid ? bus.mem_rdata : '0;
    bus.d_rdata  = bus.d_rvalid ? bus.mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resp_owner   <= OWN_NONE;
      r_conflict_cnt <= '0;
    end else begin
      if (w_grant_i)      r_resp_owner <= OWN_I;
      else if (w_grant_d) r_resp_owner <= OWN_D;
      else                r_resp_owner <= OWN_NONE;
      if (w_both) r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
endmodule
